// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset-release and reset-request controller.
//
// The raw pushbutton reset passes through a two-flop negedge synchroniser.
// Subsystem resets are then released in order: sensor, then control, then
// motor. A soft-reset request shuts them down in reverse order, holds, and
// re-runs the release sequence.
//
// Ports:
//   clk           system clock
//   RST_n         raw pushbutton reset, asynchronous, active-low
//   soft_rst_req  synchronous soft-reset request
//   rst_sens_n    inertial sensor interface reset, active-low
//   rst_ctrl_n    balance controller reset, active-low
//   rst_mtr_n     motor drive / PWM reset, active-low
//   sys_rdy       high while all stages are released (RUN)
//   rst_cause     01 = pushbutton/power-on, 10 = soft
module rst_sequencer #(
  parameter int unsigned DLY_W     = 16,
  parameter int unsigned STAGE_DLY = 5000,
  parameter int unsigned HOLD_CYC  = 16
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       soft_rst_req,
  output logic       rst_sens_n,
  output logic       rst_ctrl_n,
  output logic       rst_mtr_n,
  output logic       sys_rdy,
  output logic [1:0] rst_cause
);

  localparam logic [DLY_W-1:0] StageLast = DLY_W'(STAGE_DLY - 1);
  localparam logic [DLY_W-1:0] HoldLast  = DLY_W'(HOLD_CYC - 1);
  localparam logic [DLY_W-1:0] CntOne    = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       CausePor  = 2'b01;
  localparam logic [1:0]       CauseSoft = 2'b10;

  typedef enum logic [2:0] {
    StHold,
    StWaitSens,
    StWaitCtrl,
    StWaitMtr,
    StRun,
    StShutCtrl,
    StShutSens,
    StSoftHold
  } state_e;

  // Reset synchroniser: assertion immediate, release after two negedges.
  logic sync_meta_q;
  logic rst_sync;

  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync_meta_q <= 1'b0;
      rst_sync    <= 1'b0;
    end else begin
      sync_meta_q <= 1'b1;
      rst_sync    <= sync_meta_q;
    end
  end

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             sens_q, sens_d;
  logic             ctrl_q, ctrl_d;
  logic             mtr_q, mtr_d;
  logic             rdy_q, rdy_d;
  logic [1:0]       cause_q, cause_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sens_d  = sens_q;
    ctrl_d  = ctrl_q;
    mtr_d   = mtr_q;
    rdy_d   = rdy_q;
    cause_d = cause_q;

    unique case (state_q)
      StHold: begin
        if (rst_sync) begin
          state_d = StWaitSens;
          cnt_d   = '0;
        end
      end

      StWaitSens, StWaitCtrl, StWaitMtr: begin
        if (soft_rst_req) begin
          // Abort: drop anything already released in one step.
          sens_d  = 1'b0;
          ctrl_d  = 1'b0;
          mtr_d   = 1'b0;
          rdy_d   = 1'b0;
          cause_d = CauseSoft;
          state_d = StSoftHold;
          cnt_d   = '0;
        end else if (cnt_q == StageLast) begin
          cnt_d = '0;
          if (state_q == StWaitSens) begin
            sens_d  = 1'b1;
            state_d = StWaitCtrl;
          end else if (state_q == StWaitCtrl) begin
            ctrl_d  = 1'b1;
            state_d = StWaitMtr;
          end else begin
            mtr_d   = 1'b1;
            rdy_d   = 1'b1;
            state_d = StRun;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StRun: begin
        if (soft_rst_req) begin
          mtr_d   = 1'b0;
          rdy_d   = 1'b0;
          cause_d = CauseSoft;
          state_d = StShutCtrl;
        end
      end

      StShutCtrl: begin
        ctrl_d  = 1'b0;
        state_d = StShutSens;
      end

      StShutSens: begin
        sens_d  = 1'b0;
        state_d = StSoftHold;
        cnt_d   = '0;
      end

      StSoftHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StWaitSens;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset directly from RST_n so outputs drop in the same cycle.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      sens_q  <= 1'b0;
      ctrl_q  <= 1'b0;
      mtr_q   <= 1'b0;
      rdy_q   <= 1'b0;
      cause_q <= CausePor;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sens_q  <= sens_d;
      ctrl_q  <= ctrl_d;
      mtr_q   <= mtr_d;
      rdy_q   <= rdy_d;
      cause_q <= cause_d;
    end
  end

  assign rst_sens_n = sens_q;
  assign rst_ctrl_n = ctrl_q;
  assign rst_mtr_n  = mtr_q;
  assign sys_rdy    = rdy_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer with STAGE_DLY=8, HOLD_CYC=4.
// Output vectors are packed as {sens, ctrl, mtr, rdy, cause[1:0]}.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       RST_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       rst_sens_n;
  logic       rst_ctrl_n;
  logic       rst_mtr_n;
  logic       sys_rdy;
  logic [1:0] rst_cause;
  logic [5:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  rst_sequencer #(
    .DLY_W    (16),
    .STAGE_DLY(8),
    .HOLD_CYC (4)
  ) dut (
    .clk         (clk),
    .RST_n       (RST_n),
    .soft_rst_req(soft_rst_req),
    .rst_sens_n  (rst_sens_n),
    .rst_ctrl_n  (rst_ctrl_n),
    .rst_mtr_n   (rst_mtr_n),
    .sys_rdy     (sys_rdy),
    .rst_cause   (rst_cause)
  );

  always #5 clk = ~clk;

  assign outs = {rst_sens_n, rst_ctrl_n, rst_mtr_n, sys_rdy, rst_cause};

  typedef struct {
    int unsigned cycles;
    logic        req;
    logic [5:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int unsigned c, input logic r, input logic [5:0] e,
                         input string n);
    vec_t v;
    v.cycles = c;
    v.req    = r;
    v.exp    = e;
    v.name   = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: sens/ctrl/mtr/rdy/cause got %b required %b (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RST_n rose just after a posedge: the second posedge after is posedge 0.
  task automatic wait_pe0();
    step(2);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 RST_n = 1'b1;
    wait_pe0();
  endtask

  // Entered at the posedge-0 sample; ends at posedge 24 in RUN.
  task automatic check_timing(input logic [1:0] c);
    check("t_pe0", outs, {4'b0000, c});
    step(7);  check("t_pe7", outs, {4'b0000, c});
    step(1);  check("t_pe8", outs, {4'b1000, c});
    step(7);  check("t_pe15", outs, {4'b1000, c});
    step(1);  check("t_pe16", outs, {4'b1100, c});
    step(7);  check("t_pe23", outs, {4'b1100, c});
    step(1);  check("t_pe24", outs, {4'b1111, c});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic persist_ok;
    logic ok;

    // Power-on table, cycle counts relative to posedge 0; soft pulse at 30,
    // request kept high through shutdown and hold (ignored), abort at 48.
    add_vec(7, 1'b0, 6'b0000_01, "po_pe7");
    add_vec(1, 1'b0, 6'b1000_01, "po_sens_up");
    add_vec(7, 1'b0, 6'b1000_01, "po_pe15");
    add_vec(1, 1'b0, 6'b1100_01, "po_ctrl_up");
    add_vec(7, 1'b0, 6'b1100_01, "po_pe23");
    add_vec(1, 1'b0, 6'b1111_01, "po_run");
    add_vec(5, 1'b0, 6'b1111_01, "run_hold");
    add_vec(1, 1'b1, 6'b1100_10, "soft_k_mtr_down");
    add_vec(1, 1'b1, 6'b1000_10, "soft_k1_ctrl_down");
    add_vec(1, 1'b1, 6'b0000_10, "soft_k2_sens_down");
    add_vec(3, 1'b1, 6'b0000_10, "soft_hold_ignored");
    add_vec(1, 1'b0, 6'b0000_10, "soft_new_pe0");
    add_vec(7, 1'b0, 6'b0000_10, "re_pe7");
    add_vec(1, 1'b0, 6'b1000_10, "re_sens_up_k14");
    add_vec(3, 1'b0, 6'b1000_10, "re_pe11");
    add_vec(1, 1'b1, 6'b0000_10, "abort_pe12");
    add_vec(3, 1'b0, 6'b0000_10, "abort_hold");
    add_vec(1, 1'b0, 6'b0000_10, "abort_new_pe0");
    add_vec(7, 1'b0, 6'b0000_10, "ab_pe7");
    add_vec(1, 1'b0, 6'b1000_10, "ab_sens_up");
    add_vec(7, 1'b0, 6'b1000_10, "ab_pe15");
    add_vec(1, 1'b0, 6'b1100_10, "ab_ctrl_up");
    add_vec(7, 1'b0, 6'b1100_10, "ab_pe23");
    add_vec(1, 1'b0, 6'b1111_10, "ab_run");

    #2 RST_n = 1'b0;
    step(3);
    check("reset_state", outs, 6'b0000_01);

    release_reset();
    check("po_pe0", outs, 6'b0000_01);
    for (int i = 0; i < vecs.size(); i++) begin
      soft_rst_req = vecs[i].req;
      step(int'(vecs[i].cycles));
      check(vecs[i].name, outs, vecs[i].exp);
    end
    soft_rst_req = 1'b0;

    // Persistent request from RUN for 100 cycles.
    persist_ok   = 1'b1;
    soft_rst_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (rst_mtr_n || sys_rdy) persist_ok = 1'b0;
    end
    check_bit("persist_mtr_never_up", persist_ok, 1'b1);
    soft_rst_req = 1'b0;
    step(25);
    check("persist_pe23", outs, 6'b1100_10);
    step(1);
    check("persist_run", outs, 6'b1111_10);

    // Sub-cycle RST_n glitch while in RUN.
    @(posedge clk);
    #2 RST_n = 1'b0;
    #1 check("glitch_low", outs, 6'b0000_01);
    #1 RST_n = 1'b1;
    wait_pe0();
    check_timing(2'b01);

    // Async reset during WAIT_CTRL.
    RST_n = 1'b0;
    release_reset();
    step(10);
    check("wctrl_before", outs, 6'b1000_01);
    #3 RST_n = 1'b0;
    #1 check("wctrl_async", outs, 6'b0000_01);
    release_reset();
    check_timing(2'b01);

    // Async reset during SOFT_HOLD.
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(2);
    check("shold_before", outs, 6'b0000_10);
    step(1);
    #3 RST_n = 1'b0;
    #1 check("shold_async", outs, 6'b0000_01);
    release_reset();
    check_timing(2'b01);

    // Randomised stimulus with ordering invariants.
    for (int i = 0; i < 10000; i++) begin
      step(1);
      ok = (!rst_mtr_n || rst_ctrl_n) && (!rst_ctrl_n || rst_sens_n) &&
           (sys_rdy == rst_mtr_n) && (rst_cause == 2'b01 || rst_cause == 2'b10);
      check_bit("order_inv", ok, 1'b1);
      soft_rst_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #1 RST_n = 1'b0;
        #1 check("rand_async", outs, 6'b0000_01);
        #1 RST_n = 1'b1;
      end
    end
    soft_rst_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
